// File: rtl/meas_uart_packer.sv
// meas_uart_packer: snapshots the measurements and sends them as a 13-byte checksummed UART frame,
// either periodically or on request, with a per-byte timeout on uart_tx_done.
module meas_uart_packer #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int SEND_PERIOD_MS = 100,
  parameter int TIMEOUT_CYC    = 100_000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        send_trig,
  input  logic [31:0] duty,
  input  logic [19:0] ad_freq,
  input  logic [7:0]  ad_max,
  input  logic [7:0]  ad_min,
  input  logic        uart_tx_done,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        tx_timeout
);
  localparam logic [31:0] PER_LAST = 32'(CLK_FREQ / 1000 * SEND_PERIOD_MS - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
  state_t state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] per_q, per_d, to_q, to_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] duty_q, duty_d;
  logic [19:0] freq_q, freq_d;
  logic [7:0]  max_q, max_d, min_q, min_d;
  logic        en_q, en_d, busy_q, busy_d, tout_q, tout_d;
  logic [7:0]  data_q, data_d, chk;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        per_wrap, done_w, last, tout_w;
  logic [12:0][7:0] fb;
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      per_q       <= '0;
      to_q        <= '0;
      idx_q       <= '0;
      duty_q      <= '0;
      freq_q      <= '0;
      max_q       <= '0;
      min_q       <= '0;
      en_q        <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      per_q       <= per_d;
      to_q        <= to_d;
      idx_q       <= idx_d;
      duty_q      <= duty_d;
      freq_q      <= freq_d;
      max_q       <= max_d;
      min_q       <= min_d;
      en_q        <= en_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      tout_q      <= tout_d;
    end
  end
  // A trigger, a period wrap and any number of repeats collapse into one pending flag.
  always_comb begin
    per_wrap = per_q == PER_LAST;
    per_d    = per_wrap ? '0 : per_q + 32'd1;
    pend_d   = send_trig | per_wrap | (pend_q & (state_q != LOAD));
    done_w   = (state_q == WAIT) & uart_tx_done;
    last     = idx_q == 4'd12;
    to_d     = (state_q == SEND) ? '0 : (state_q == WAIT) ? to_q + 32'd1 : to_q;
    tout_w   = (state_q == WAIT) & ~uart_tx_done & (to_d == TO_LAST);
    idx_d    = (state_q == LOAD) ? 4'd0 : (done_w & ~last) ? idx_q + 4'd1 : idx_q;
    duty_d   = (state_q == LOAD) ? duty : duty_q;
    freq_d   = (state_q == LOAD) ? ad_freq : freq_q;
    max_d    = (state_q == LOAD) ? ad_max : max_q;
    min_d    = (state_q == LOAD) ? ad_min : min_q;
    state_d  = state_q;
    case (state_q)
      IDLE:    state_d = pend_q ? LOAD : IDLE;
      LOAD:    state_d = SEND;
      SEND:    state_d = WAIT;
      WAIT:    state_d = done_w ? (last ? IDLE : SEND) : tout_w ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  // Bytes come from the _d snapshot so byte 0 can be loaded on the LOAD->SEND edge.
  always_comb begin
    chk = {4'h0, freq_d[19:16]} + freq_d[15:8] + freq_d[7:0] + duty_d[31:24] + duty_d[23:16]
        + duty_d[15:8] + duty_d[7:0] + max_d + min_d;
    fb = {8'h0D, chk, min_d, max_d, duty_d[7:0], duty_d[15:8], duty_d[23:16], duty_d[31:24],
          freq_d[7:0], freq_d[15:8], {4'h0, freq_d[19:16]}, 8'h5A, 8'hA5};
    en_d        = state_d == SEND;
    data_d      = en_d ? fb[idx_d] : data_q;
    busy_d      = state_d != IDLE;
    frame_cnt_d = frame_cnt_q + 16'(done_w & last);
    tout_d      = tout_w;
  end
  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;
  assign tx_timeout   = tout_q;
endmodule

// File: tb/tb_meas_uart_packer.sv
// tb_meas_uart_packer: directed checks of frame content and timing, timeout, trigger coalescing,
// mid-frame reset, periodic frames and frame counter wrap.
module tb_meas_uart_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic        rst_a = 1'b1, rst_b = 1'b1, trig_a = 1'b0, trig_b = 1'b0;
  logic [31:0] duty = '0;
  logic [19:0] ad_freq = '0;
  logic [7:0]  ad_max = '0, ad_min = '0;
  logic        done_r = 1'b0, done_m = 1'b0, done_a, done_b = 1'b0;
  logic        en_a, busy_a, tout_a, en_b, busy_b, tout_b;
  logic [7:0]  data_a, data_b;
  logic [15:0] fcnt_a, fcnt_b;
  assign done_a = done_r | done_m;
  meas_uart_packer #(.CLK_FREQ(1_000_000), .SEND_PERIOD_MS(50), .TIMEOUT_CYC(20)) dut_a (
    .sys_clk(clk), .rst(rst_a), .send_trig(trig_a), .duty(duty), .ad_freq(ad_freq),
    .ad_max(ad_max), .ad_min(ad_min), .uart_tx_done(done_a), .uart_tx_en(en_a),
    .uart_tx_data(data_a), .busy(busy_a), .frame_cnt(fcnt_a), .tx_timeout(tout_a));
  meas_uart_packer #(.CLK_FREQ(10_000), .SEND_PERIOD_MS(1), .TIMEOUT_CYC(3)) dut_b (
    .sys_clk(clk), .rst(rst_b), .send_trig(trig_b), .duty(duty), .ad_freq(ad_freq),
    .ad_max(ad_max), .ad_min(ad_min), .uart_tx_done(done_b), .uart_tx_en(en_b),
    .uart_tx_data(data_b), .busy(busy_b), .frame_cnt(fcnt_b), .tx_timeout(tout_b));
  logic [7:0] bytes_a[$];
  int ecyc_a[$], ecyc_b[$], tcyc_b[$];
  int n_chk = 0, n_fail = 0;
  int dly = 5, drop = -1, nb = 0;
  logic [7:0] exp1 [13] = '{8'hA5, 8'h5A, 8'h00, 8'h1F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h32,
                            8'hC8, 8'h10, 8'h69, 8'h0D};
  logic [7:0] exp2 [13] = '{8'hA5, 8'h5A, 8'h0A, 8'hBC, 8'hDE, 8'h12, 8'h34, 8'h56, 8'h78,
                            8'h9A, 8'h01, 8'h53, 8'h0D};
  always @(negedge clk) begin
    if (en_a) begin
      bytes_a.push_back(data_a);
      ecyc_a.push_back(cyc);
    end
    if (en_b) ecyc_b.push_back(cyc);
    if (tout_b) tcyc_b.push_back(cyc);
  end
  // UART model for dut_a: done arrives dly cycles after each en, except for byte number drop.
  initial forever begin
    @(negedge clk);
    while (en_a && nb != drop) begin
      nb++;
      repeat (dly) @(negedge clk);
      done_r = 1'b1;
      @(negedge clk);
      done_r = 1'b0;
    end
    if (en_a) nb++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (bytes_a.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, " byte count"}, bytes_a.size(), n);
  endtask
  task automatic reset_a();
    rst_a = 1'b1;
    tick(2);
    rst_a = 1'b0;
    bytes_a.delete();
    ecyc_a.delete();
    nb = 0;
    drop = -1;
  endtask
  task automatic pulse_a();
    trig_a = 1'b1;
    tick(1);
    trig_a = 1'b0;
  endtask
  task automatic set_in2();
    ad_freq = 20'hABCDE;
    duty    = 32'h12345678;
    ad_max  = 8'h9A;
    ad_min  = 8'h01;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int t0, tc, e, c0;
    tick(3);
    check("rst en", en_a, 0);
    check("rst data", data_a, 0);
    check("rst busy", busy_a, 0);
    check("rst frame_cnt", fcnt_a, 0);
    check("rst timeout", tout_a, 0);
    // Reference frame, done 5 cycles after each en
    reset_a();
    ad_freq = 20'h01F40;
    duty    = 32'h32;
    ad_max  = 8'hC8;
    ad_min  = 8'h10;
    dly = 5;
    tick(2);
    t0 = cyc;
    pulse_a();
    wait_bytes(13, 200, "ref");
    for (int i = 0; i < 13; i++) check($sformatf("ref byte%0d", i), bytes_a[i], exp1[i]);
    check("ref trig to en", ecyc_a[0] - t0, 3);
    check("ref en spacing", ecyc_a[1] - ecyc_a[0], 6);
    check("ref frame length", ecyc_a[12] - ecyc_a[0], 72);
    tick(5);
    check("ref busy last wait", busy_a, 1);
    check("ref cnt last wait", fcnt_a, 0);
    tick(1);
    check("ref busy done", busy_a, 0);
    check("ref cnt done", fcnt_a, 1);
    check("ref en idle", en_a, 0);
    check("ref data hold", data_a, 8'h0D);
    // Inputs change mid-frame; frame keeps the LOAD-time snapshot
    reset_a();
    set_in2();
    dly = 1;
    pulse_a();
    wait_bytes(2, 20, "snap head");
    duty    = 32'hFFFF_FFFF;
    ad_freq = 20'hFFFFF;
    ad_max  = 8'hFF;
    ad_min  = 8'hFF;
    wait_bytes(13, 60, "snap");
    for (int i = 0; i < 13; i++) check($sformatf("snap byte%0d", i), bytes_a[i], exp2[i]);
    check("snap min spacing", ecyc_a[1] - ecyc_a[0], 2);
    tick(3);
    check("snap cnt", fcnt_a, 1);
    // Timeout on byte 4 with a retrigger pending
    reset_a();
    dly = 1;
    drop = 4;
    pulse_a();
    wait_bytes(5, 40, "to");
    e = ecyc_a[4];
    pulse_a();
    tc = -1;
    for (int k = 0; k < 40 && tc < 0; k++) begin
      tick(1);
      if (tout_a) tc = cyc;
    end
    check("to delay", tc - e, 20);
    check("to busy", busy_a, 0);
    check("to cnt", fcnt_a, 0);
    drop = -1;
    tick(1);
    check("to one cycle", tout_a, 0);
    wait_bytes(18, 60, "to restart");
    check("to restart head", bytes_a[5], 8'hA5);
    check("to restart delay", ecyc_a[5] - tc, 2);
    tick(3);
    check("to restart cnt", fcnt_a, 1);
    // Two triggers during one frame give one extra frame
    reset_a();
    set_in2();
    dly = 1;
    pulse_a();
    wait_bytes(3, 20, "coal");
    pulse_a();
    tick(2);
    pulse_a();
    wait_bytes(26, 100, "coal");
    check("coal second head", bytes_a[13], 8'hA5);
    check("coal gap", ecyc_a[13] - ecyc_a[12], 4);
    tick(60);
    check("coal total bytes", bytes_a.size(), 26);
    check("coal cnt", fcnt_a, 2);
    // Reset asserted during the WAIT of byte 7
    reset_a();
    dly = 1;
    pulse_a();
    wait_bytes(13, 60, "mid");
    tick(3);
    check("mid cnt before", fcnt_a, 1);
    drop = 20;
    pulse_a();
    wait_bytes(21, 40, "mid");
    tick(1);
    rst_a = 1'b1;
    tick(1);
    check("mid rst en", en_a, 0);
    check("mid rst data", data_a, 0);
    check("mid rst busy", busy_a, 0);
    check("mid rst cnt", fcnt_a, 0);
    check("mid rst timeout", tout_a, 0);
    tick(2);
    rst_a = 1'b0;
    tc = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (tout_a) tc++;
    end
    check("mid no en after", bytes_a.size(), 21);
    check("mid no timeout", tc, 0);
    // Done in IDLE and SEND is ignored; counter wraps
    reset_a();
    dly = 1;
    done_m = 1'b1;
    tick(1);
    done_m = 1'b0;
    tick(1);
    check("idle done busy", busy_a, 0);
    check("idle done cnt", fcnt_a, 0);
    force dut_a.frame_cnt_q = 16'hFFFF;
    tick(2);
    release dut_a.frame_cnt_q;
    tick(1);
    check("wrap preset", fcnt_a, 16'hFFFF);
    drop = 12;
    pulse_a();
    wait_bytes(13, 60, "send done");
    done_m = 1'b1;
    tick(1);
    done_m = 1'b0;
    check("send done cnt", fcnt_a, 16'hFFFF);
    check("send done busy", busy_a, 1);
    tc = -1;
    for (int k = 0; k < 30 && tc < 0; k++) begin
      tick(1);
      if (tout_a) tc = cyc;
    end
    check("send done timeout", tc - ecyc_a[12], 20);
    drop = -1;
    pulse_a();
    wait_bytes(26, 60, "wrap");
    tick(3);
    check("wrap cnt", fcnt_a, 16'h0000);
    // Periodic frames on dut_b (P=10), trigger coinciding with a wrap
    rst_a = 1'b1;
    ecyc_b.delete();
    tcyc_b.delete();
    rst_b = 1'b0;
    c0 = cyc;
    tick(19);
    trig_b = 1'b1;
    tick(1);
    trig_b = 1'b0;
    tick(20);
    check("per frames", ecyc_b.size(), 3);
    check("per first", ecyc_b[0] - c0, 12);
    check("per second", ecyc_b[1] - c0, 22);
    check("per third", ecyc_b[2] - c0, 32);
    check("per timeout", tcyc_b[0] - c0, 15);
    check("per cnt", fcnt_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
